mc_control_fsm: RTL and testbench
=================================

MC_CONTROL_FSM -- requirements
Module: mc_control_fsm

Interface
REQ-001 SHALL have one clock and an asynchronous active-low reset: clk in, rst_n in.
REQ-002 Ports (name  direction  width  meaning):
clk  in  1  sole clock, rising edge
rst_n  in  1  async active-low reset
opcode  in  7  IR[6:0]
funct3  in  3  IR[14:12]
br_taken  in  1  external branch comparator result for current IR
mem_ready  in  1  memory completes the current request this cycle
mem_req  out  1  memory request, held until mem_ready
mem_we  out  1  1=store, 0=fetch/load
ir_we  out  1  latch IR and old_pc
pc_we  out  1  PC write enable
pc_src  out  1  0=ALU combinational result, 1=alu_out register
alu_op  out  2  to alu_control: 00 add, 01 sub, 10 funct-decoded
alu_f7_en  out  1  gate for funct7b5 into alu_control
alu_src_a  out  2  00 PC, 01 old_pc, 10 rs1
alu_src_b  out  2  00 rs2, 01 imm, 10 const 4
rf_we  out  1  register file write enable
wb_sel  out  2  00 alu_out, 01 mem data, 10 PC, 11 imm
retire  out  1  one-cycle pulse per completed instruction
illegal  out  1  sticky illegal-opcode flag
state  out  4  current state, debug

Function
REQ-003 SHALL be a multi-cycle RV32I sequencer; outputs decoded from state (Moore), except pc_we/ir_we/retire/next-state, which also depend on mem_ready or br_taken as stated.
REQ-004 States: FETCH, DECODE, EXEC_R, EXEC_I, MEM_ADDR, MEM_RD, MEM_WR, WB_ALU, WB_MEM, BRANCH, JAL, JALR, LUI, AUIPC, TRAP.
REQ-005 Unlisted outputs SHALL be 0 in every state; unused mux selects SHALL be 00.
REQ-006 FETCH: mem_req=1, mem_we=0, src_a=00, src_b=10, alu_op=00; if mem_ready then ir_we=1, pc_we=1, pc_src=0, go DECODE; else stay, enables 0.
REQ-007 DECODE: src_a=01, src_b=01, alu_op=00 (branch/JAL target into alu_out); next by opcode: 0110011 EXEC_R, 0010011 EXEC_I, 0000011/0100011 MEM_ADDR, 1100011 BRANCH, 1101111 JAL, 1100111 JALR, 0110111 LUI, 0010111 AUIPC, any other TRAP.
REQ-008 EXEC_R: src_a=10, src_b=00, alu_op=10, alu_f7_en=1 -> WB_ALU.
REQ-009 EXEC_I: src_a=10, src_b=01, alu_op=10, alu_f7_en=1 only if funct3=101 (ADDI imm[10] never selects SUB) -> WB_ALU.
REQ-010 MEM_ADDR: src_a=10, src_b=01, alu_op=00 -> MEM_RD if opcode=0000011 else MEM_WR.
REQ-011 MEM_RD: mem_req=1, mem_we=0; stay until mem_ready -> WB_MEM. MEM_WR: mem_req=1, mem_we=1; on mem_ready retire=1 -> FETCH.
REQ-012 WB_ALU: rf_we=1, wb_sel=00, retire=1 -> FETCH. WB_MEM: rf_we=1, wb_sel=01, retire=1 -> FETCH.
REQ-013 BRANCH: src_a=10, src_b=00, alu_op=01; pc_we=br_taken, pc_src=1; retire=1 -> FETCH.
REQ-014 JAL: rf_we=1, wb_sel=10, pc_we=1, pc_src=1, retire=1 -> FETCH (rf samples PC=old_pc+4 before update).
REQ-015 JALR: src_a=10, src_b=01, alu_op=00, pc_we=1, pc_src=0, rf_we=1, wb_sel=10, retire=1 -> FETCH; LSB clear done in datapath.
REQ-016 LUI: rf_we=1, wb_sel=11, retire=1 -> FETCH. AUIPC: src_a=01, src_b=01, alu_op=00 -> WB_ALU.
REQ-017 TRAP: illegal=1, all enables 0, mem_req=0; absorbing until reset.
REQ-018 mem_req SHALL NOT drop, nor mem_we change, while waiting; mem_ready outside FETCH/MEM_RD/MEM_WR SHALL be ignored.
REQ-019 Latency without wait states: R/I/AUIPC 4, load 5, store 4, branch/JAL/JALR/LUI 3 cycles; each mem wait cycle adds 1.

Reset
REQ-020 rst_n low SHALL force state=FETCH and illegal=0 asynchronously; mid-access reset abandons the access, mem_req reasserts as a new fetch after release.
REQ-021 During reset outputs SHALL equal FETCH decoding with pc_we=ir_we=retire=0.

Structure
REQ-022 State encoding, opcode constants and mux-select encodings SHALL live in shared package rv32_ctrl_pkg, also used by the datapath.
REQ-023 Opcode-to-next-state decode SHALL be one combinational sub-module, mc_opcode_decode.

Verification
REQ-024 ADD (0x002081B3), mem_ready=1 always -> FETCH,DECODE,EXEC_R,WB_ALU; rf_we=1 in cycle 4 only, retire pulse once.
REQ-025 LW (0x0000A103), mem_ready low 2 cycles in MEM_RD -> mem_req held 3 cycles, WB_MEM in cycle 7, wb_sel=01.
REQ-026 BEQ, br_taken=0 then br_taken=1 -> pc_we=0 vs pc_we=1, pc_src=1 in BRANCH; both 3 cycles.
REQ-027 ADDI x1,x0,-1024 (imm[10]=1) -> alu_op=10, alu_f7_en=0; SRAI -> alu_f7_en=1.
REQ-028 Opcode 0x7F -> TRAP, illegal=1 sticky for 100 cycles, no enables; rst_n pulse -> FETCH, illegal=0.
REQ-029 rst_n asserted mid-MEM_WR -> mem_req, mem_we drop without clk edge; after release FETCH with mem_we=0.

Source files
------------

// File: rtl/rv32_ctrl_pkg.sv
// rv32_ctrl_pkg: shared state encoding, opcodes, mux selects and Moore decode for the multi-cycle RV32I control
package rv32_ctrl_pkg;

    typedef enum logic [3:0] {
        S_FETCH,
        S_DECODE,
        S_EXEC_R,
        S_EXEC_I,
        S_MEM_ADDR,
        S_MEM_RD,
        S_MEM_WR,
        S_WB_ALU,
        S_WB_MEM,
        S_BRANCH,
        S_JAL,
        S_JALR,
        S_LUI,
        S_AUIPC,
        S_TRAP
    } state_t;

    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;

    localparam logic [2:0] F3_SR = 3'b101;

    localparam logic [1:0] ALU_ADD   = 2'b00;
    localparam logic [1:0] ALU_SUB   = 2'b01;
    localparam logic [1:0] ALU_FUNCT = 2'b10;

    localparam logic [1:0] SRCA_PC    = 2'b00;
    localparam logic [1:0] SRCA_OLDPC = 2'b01;
    localparam logic [1:0] SRCA_RS1   = 2'b10;

    localparam logic [1:0] SRCB_RS2  = 2'b00;
    localparam logic [1:0] SRCB_IMM  = 2'b01;
    localparam logic [1:0] SRCB_FOUR = 2'b10;

    localparam logic [1:0] WBSEL_ALU = 2'b00;
    localparam logic [1:0] WBSEL_MEM = 2'b01;
    localparam logic [1:0] WBSEL_PC  = 2'b10;
    localparam logic [1:0] WBSEL_IMM = 2'b11;

    localparam logic PCSRC_ALU    = 1'b0;
    localparam logic PCSRC_ALUOUT = 1'b1;

    typedef struct packed {
        logic       mem_req;
        logic       mem_we;
        logic       pc_src;
        logic [1:0] alu_op;
        logic       alu_f7_en;
        logic [1:0] alu_src_a;
        logic [1:0] alu_src_b;
        logic       rf_we;
        logic [1:0] wb_sel;
        logic       illegal;
    } ctrl_t;

    // Moore outputs of a state; funct3 only matters for the shift-immediate funct7 gate
    function automatic ctrl_t moore_ctrl(input state_t s, input logic [2:0] f3);
        ctrl_t c;
        c = '0;
        case (s)
            S_FETCH: begin
                c.mem_req   = 1'b1;
                c.alu_src_a = SRCA_PC;
                c.alu_src_b = SRCB_FOUR;
                c.alu_op    = ALU_ADD;
                c.pc_src    = PCSRC_ALU;
            end
            S_DECODE: begin
                c.alu_src_a = SRCA_OLDPC;
                c.alu_src_b = SRCB_IMM;
            end
            S_EXEC_R: begin
                c.alu_src_a = SRCA_RS1;
                c.alu_src_b = SRCB_RS2;
                c.alu_op    = ALU_FUNCT;
                c.alu_f7_en = 1'b1;
            end
            S_EXEC_I: begin
                c.alu_src_a = SRCA_RS1;
                c.alu_src_b = SRCB_IMM;
                c.alu_op    = ALU_FUNCT;
                c.alu_f7_en = (f3 == F3_SR);
            end
            S_MEM_ADDR: begin
                c.alu_src_a = SRCA_RS1;
                c.alu_src_b = SRCB_IMM;
            end
            S_MEM_RD: c.mem_req = 1'b1;
            S_MEM_WR: begin
                c.mem_req = 1'b1;
                c.mem_we  = 1'b1;
            end
            S_WB_ALU: begin
                c.rf_we  = 1'b1;
                c.wb_sel = WBSEL_ALU;
            end
            S_WB_MEM: begin
                c.rf_we  = 1'b1;
                c.wb_sel = WBSEL_MEM;
            end
            S_BRANCH: begin
                c.alu_src_a = SRCA_RS1;
                c.alu_src_b = SRCB_RS2;
                c.alu_op    = ALU_SUB;
                c.pc_src    = PCSRC_ALUOUT;
            end
            S_JAL: begin
                c.rf_we  = 1'b1;
                c.wb_sel = WBSEL_PC;
                c.pc_src = PCSRC_ALUOUT;
            end
            S_JALR: begin
                c.alu_src_a = SRCA_RS1;
                c.alu_src_b = SRCB_IMM;
                c.pc_src    = PCSRC_ALU;
                c.rf_we     = 1'b1;
                c.wb_sel    = WBSEL_PC;
            end
            S_LUI: begin
                c.rf_we  = 1'b1;
                c.wb_sel = WBSEL_IMM;
            end
            S_AUIPC: begin
                c.alu_src_a = SRCA_OLDPC;
                c.alu_src_b = SRCB_IMM;
            end
            S_TRAP: c.illegal = 1'b1;
            default: c = '0;
        endcase
        return c;
    endfunction

endpackage

// File: rtl/mc_opcode_decode.sv
// mc_opcode_decode: maps the IR opcode to the state that follows DECODE
module mc_opcode_decode
    import rv32_ctrl_pkg::*;
(
    input  logic [6:0] opcode,
    output state_t     next_state
);

    // Unknown opcodes fall through to TRAP
    always_comb begin
        case (opcode)
            OP_R:               next_state = S_EXEC_R;
            OP_IMM:             next_state = S_EXEC_I;
            OP_LOAD, OP_STORE:  next_state = S_MEM_ADDR;
            OP_BRANCH:          next_state = S_BRANCH;
            OP_JAL:             next_state = S_JAL;
            OP_JALR:            next_state = S_JALR;
            OP_LUI:             next_state = S_LUI;
            OP_AUIPC:           next_state = S_AUIPC;
            default:            next_state = S_TRAP;
        endcase
    end

endmodule

// File: rtl/mc_control_fsm.sv
// mc_control_fsm: multi-cycle RV32I sequencer with registered Moore controls and handshake-qualified enables
module mc_control_fsm
    import rv32_ctrl_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic [6:0] opcode,
    input  logic [2:0] funct3,
    input  logic       br_taken,
    input  logic       mem_ready,
    output logic       mem_req,
    output logic       mem_we,
    output logic       ir_we,
    output logic       pc_we,
    output logic       pc_src,
    output logic [1:0] alu_op,
    output logic       alu_f7_en,
    output logic [1:0] alu_src_a,
    output logic [1:0] alu_src_b,
    output logic       rf_we,
    output logic [1:0] wb_sel,
    output logic       retire,
    output logic       illegal,
    output logic [3:0] state
);

    state_t state_q, state_d, dec_state;
    ctrl_t  ctrl_q, ctrl_d;

    mc_opcode_decode u_dec (
        .opcode     (opcode),
        .next_state (dec_state)
    );

    // Next state; mem_ready only matters in the three memory states
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_FETCH:    state_d = mem_ready ? S_DECODE : S_FETCH;
            S_DECODE:   state_d = dec_state;
            S_EXEC_R:   state_d = S_WB_ALU;
            S_EXEC_I:   state_d = S_WB_ALU;
            S_MEM_ADDR: state_d = (opcode == OP_LOAD) ? S_MEM_RD : S_MEM_WR;
            S_MEM_RD:   state_d = mem_ready ? S_WB_MEM : S_MEM_RD;
            S_MEM_WR:   state_d = mem_ready ? S_FETCH : S_MEM_WR;
            S_AUIPC:    state_d = S_WB_ALU;
            S_TRAP:     state_d = S_TRAP;
            default:    state_d = S_FETCH;
        endcase
        ctrl_d = moore_ctrl(state_d, funct3);
    end

    // State and Moore controls are registered together so outputs are glitch-free
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_FETCH;
            ctrl_q  <= moore_ctrl(S_FETCH, 3'b000);
        end else begin
            state_q <= state_d;
            ctrl_q  <= ctrl_d;
        end
    end

    // Handshake/branch qualified strobes; all suppressed while reset is held
    always_comb begin
        ir_we  = rst_n && (state_q == S_FETCH) && mem_ready;
        pc_we  = rst_n && (((state_q == S_FETCH) && mem_ready) ||
                           ((state_q == S_BRANCH) && br_taken) ||
                           (state_q == S_JAL) || (state_q == S_JALR));
        retire = rst_n && ((state_q == S_WB_ALU) || (state_q == S_WB_MEM) ||
                           (state_q == S_BRANCH) || (state_q == S_JAL) ||
                           (state_q == S_JALR) || (state_q == S_LUI) ||
                           ((state_q == S_MEM_WR) && mem_ready));
    end

    // A reset abandons any access at once; the new fetch request appears on release
    assign mem_req   = ctrl_q.mem_req && rst_n;
    assign mem_we    = ctrl_q.mem_we && rst_n;
    assign pc_src    = ctrl_q.pc_src;
    assign alu_op    = ctrl_q.alu_op;
    assign alu_f7_en = ctrl_q.alu_f7_en;
    assign alu_src_a = ctrl_q.alu_src_a;
    assign alu_src_b = ctrl_q.alu_src_b;
    assign rf_we     = ctrl_q.rf_we;
    assign wb_sel    = ctrl_q.wb_sel;
    assign illegal   = ctrl_q.illegal;
    assign state     = state_q;

endmodule

// File: tb/tb_mc_control_fsm.sv
// tb_mc_control_fsm: table-driven cycle-by-cycle check of the sequencer plus reset/trap corner sequences
module tb_mc_control_fsm;
    import rv32_ctrl_pkg::*;

    localparam logic [6:0] R_OP  = 7'h33;
    localparam logic [6:0] I_OP  = 7'h13;
    localparam logic [6:0] L_OP  = 7'h03;
    localparam logic [6:0] S_OP  = 7'h23;
    localparam logic [6:0] B_OP  = 7'h63;
    localparam logic [6:0] J_OP  = 7'h6F;
    localparam logic [6:0] JR_OP = 7'h67;
    localparam logic [6:0] U_OP  = 7'h37;
    localparam logic [6:0] A_OP  = 7'h17;
    localparam logic [6:0] X_OP  = 7'h7F;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [6:0] opcode;
    logic [2:0] funct3;
    logic       br_taken, mem_ready;
    logic       mem_req, mem_we, ir_we, pc_we, pc_src, alu_f7_en, rf_we, retire, illegal;
    logic [1:0] alu_op, alu_src_a, alu_src_b, wb_sel;
    logic [3:0] state;

    int pass_cnt = 0;
    int total    = 0;

    typedef struct {
        logic [6:0]  op;
        logic [2:0]  f3;
        logic        bt;
        logic        mr;
        logic [20:0] exp;
    } vec_t;

    vec_t vecs[$];

    mc_control_fsm dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .opcode    (opcode),
        .funct3    (funct3),
        .br_taken  (br_taken),
        .mem_ready (mem_ready),
        .mem_req   (mem_req),
        .mem_we    (mem_we),
        .ir_we     (ir_we),
        .pc_we     (pc_we),
        .pc_src    (pc_src),
        .alu_op    (alu_op),
        .alu_f7_en (alu_f7_en),
        .alu_src_a (alu_src_a),
        .alu_src_b (alu_src_b),
        .rf_we     (rf_we),
        .wb_sel    (wb_sel),
        .retire    (retire),
        .illegal   (illegal),
        .state     (state)
    );

    always #5 clk = ~clk;

    function automatic vec_t mk(input logic [6:0] op, input logic [2:0] f3, input logic bt, input logic mr,
                                input logic [3:0] st, input logic mreq, input logic mwe, input logic irw,
                                input logic pcw, input logic pcs, input logic [1:0] aop, input logic f7,
                                input logic [1:0] sa, input logic [1:0] sb, input logic rf,
                                input logic [1:0] wb, input logic ret, input logic ill);
        vec_t v;
        v.op  = op;
        v.f3  = f3;
        v.bt  = bt;
        v.mr  = mr;
        v.exp = {st, mreq, mwe, irw, pcw, pcs, aop, f7, sa, sb, rf, wb, ret, ill};
        return v;
    endfunction

    function automatic vec_t fr(input logic [6:0] op, input logic mr);
        return mk(op, 3'd0, 1'b0, mr, S_FETCH, 1, 0, mr, mr, 0, 2'd0, 0, 2'd0, 2'd2, 0, 2'd0, 0, 0);
    endfunction

    function automatic vec_t dr(input logic [6:0] op, input logic [2:0] f3);
        return mk(op, f3, 1'b0, 1'b1, S_DECODE, 0, 0, 0, 0, 0, 2'd0, 0, 2'd1, 2'd1, 0, 2'd0, 0, 0);
    endfunction

    function automatic logic [20:0] actual();
        return {state, mem_req, mem_we, ir_we, pc_we, pc_src, alu_op, alu_f7_en,
                alu_src_a, alu_src_b, rf_we, wb_sel, retire, illegal};
    endfunction

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got === exp) pass_cnt++;
        else $display("FAIL %s: got %h expected %h", name, got, exp);
    endtask

    task automatic apply(input vec_t v, input string name);
        opcode    = v.op;
        funct3    = v.f3;
        br_taken  = v.bt;
        mem_ready = v.mr;
        #1;
        check(name, {11'd0, actual()}, {11'd0, v.exp});
        @(negedge clk);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time exceeded");
        $fatal(1);
    end

    initial begin
        rst_n     = 1'b0;
        opcode    = R_OP;
        funct3    = 3'd0;
        br_taken  = 1'b0;
        mem_ready = 1'b1;
        #12;
        check("reset_state", {28'd0, state}, {28'd0, S_FETCH});
        check("reset_enables", {29'd0, mem_req, ir_we, pc_we}, 32'd0);
        check("reset_srcb", {30'd0, alu_src_b}, 32'd2);
        check("reset_flags", {29'd0, retire, illegal, mem_we}, 32'd0);

        // ADD x3,x1,x2
        vecs.push_back(fr(R_OP, 1));
        vecs.push_back(dr(R_OP, 3'd0));
        vecs.push_back(mk(R_OP, 3'd0, 0, 1, S_EXEC_R, 0, 0, 0, 0, 0, 2'd2, 1, 2'd2, 2'd0, 0, 2'd0, 0, 0));
        vecs.push_back(mk(R_OP, 3'd0, 0, 1, S_WB_ALU, 0, 0, 0, 0, 0, 2'd0, 0, 2'd0, 2'd0, 1, 2'd0, 1, 0));
        // ADDI x1,x0,-1024 with one fetch wait
        vecs.push_back(fr(I_OP, 0));
        vecs.push_back(fr(I_OP, 1));
        vecs.push_back(dr(I_OP, 3'd0));
        vecs.push_back(mk(I_OP, 3'd0, 0, 1, S_EXEC_I, 0, 0, 0, 0, 0, 2'd2, 0, 2'd2, 2'd1, 0, 2'd0, 0, 0));
        vecs.push_back(mk(I_OP, 3'd0, 0, 1, S_WB_ALU, 0, 0, 0, 0, 0, 2'd0, 0, 2'd0, 2'd0, 1, 2'd0, 1, 0));
        // SRAI
        vecs.push_back(fr(I_OP, 1));
        vecs.push_back(dr(I_OP, 3'd5));
        vecs.push_back(mk(I_OP, 3'd5, 0, 1, S_EXEC_I, 0, 0, 0, 0, 0, 2'd2, 1, 2'd2, 2'd1, 0, 2'd0, 0, 0));
        vecs.push_back(mk(I_OP, 3'd5, 0, 1, S_WB_ALU, 0, 0, 0, 0, 0, 2'd0, 0, 2'd0, 2'd0, 1, 2'd0, 1, 0));
        // LW with two wait cycles
        vecs.push_back(fr(L_OP, 1));
        vecs.push_back(dr(L_OP, 3'd2));
        vecs.push_back(mk(L_OP, 3'd2, 0, 1, S_MEM_ADDR, 0, 0, 0, 0, 0, 2'd0, 0, 2'd2, 2'd1, 0, 2'd0, 0, 0));
        vecs.push_back(mk(L_OP, 3'd2, 0, 0, S_MEM_RD, 1, 0, 0, 0, 0, 2'd0, 0, 2'd0, 2'd0, 0, 2'd0, 0, 0));
        vecs.push_back(mk(L_OP, 3'd2, 0, 0, S_MEM_RD, 1, 0, 0, 0, 0, 2'd0, 0, 2'd0, 2'd0, 0, 2'd0, 0, 0));
        vecs.push_back(mk(L_OP, 3'd2, 0, 1, S_MEM_RD, 1, 0, 0, 0, 0, 2'd0, 0, 2'd0, 2'd0, 0, 2'd0, 0, 0));
        vecs.push_back(mk(L_OP, 3'd2, 0, 1, S_WB_MEM, 0, 0, 0, 0, 0, 2'd0, 0, 2'd0, 2'd0, 1, 2'd1, 1, 0));
        // SW with one wait cycle
        vecs.push_back(fr(S_OP, 1));
        vecs.push_back(dr(S_OP, 3'd2));
        vecs.push_back(mk(S_OP, 3'd2, 0, 1, S_MEM_ADDR, 0, 0, 0, 0, 0, 2'd0, 0, 2'd2, 2'd1, 0, 2'd0, 0, 0));
        vecs.push_back(mk(S_OP, 3'd2, 0, 0, S_MEM_WR, 1, 1, 0, 0, 0, 2'd0, 0, 2'd0, 2'd0, 0, 2'd0, 0, 0));
        vecs.push_back(mk(S_OP, 3'd2, 0, 1, S_MEM_WR, 1, 1, 0, 0, 0, 2'd0, 0, 2'd0, 2'd0, 0, 2'd0, 1, 0));
        // BEQ not taken, then taken
        vecs.push_back(fr(B_OP, 1));
        vecs.push_back(dr(B_OP, 3'd0));
        vecs.push_back(mk(B_OP, 3'd0, 0, 1, S_BRANCH, 0, 0, 0, 0, 1, 2'd1, 0, 2'd2, 2'd0, 0, 2'd0, 1, 0));
        vecs.push_back(fr(B_OP, 1));
        vecs.push_back(dr(B_OP, 3'd0));
        vecs.push_back(mk(B_OP, 3'd0, 1, 1, S_BRANCH, 0, 0, 0, 1, 1, 2'd1, 0, 2'd2, 2'd0, 0, 2'd0, 1, 0));
        // JAL, JALR, LUI
        vecs.push_back(fr(J_OP, 1));
        vecs.push_back(dr(J_OP, 3'd0));
        vecs.push_back(mk(J_OP, 3'd0, 0, 1, S_JAL, 0, 0, 0, 1, 1, 2'd0, 0, 2'd0, 2'd0, 1, 2'd2, 1, 0));
        vecs.push_back(fr(JR_OP, 1));
        vecs.push_back(dr(JR_OP, 3'd0));
        vecs.push_back(mk(JR_OP, 3'd0, 0, 1, S_JALR, 0, 0, 0, 1, 0, 2'd0, 0, 2'd2, 2'd1, 1, 2'd2, 1, 0));
        vecs.push_back(fr(U_OP, 1));
        vecs.push_back(dr(U_OP, 3'd0));
        vecs.push_back(mk(U_OP, 3'd0, 0, 1, S_LUI, 0, 0, 0, 0, 0, 2'd0, 0, 2'd0, 2'd0, 1, 2'd3, 1, 0));
        // AUIPC
        vecs.push_back(fr(A_OP, 1));
        vecs.push_back(dr(A_OP, 3'd0));
        vecs.push_back(mk(A_OP, 3'd0, 0, 1, S_AUIPC, 0, 0, 0, 0, 0, 2'd0, 0, 2'd1, 2'd1, 0, 2'd0, 0, 0));
        vecs.push_back(mk(A_OP, 3'd0, 0, 1, S_WB_ALU, 0, 0, 0, 0, 0, 2'd0, 0, 2'd0, 2'd0, 1, 2'd0, 1, 0));
        // Illegal opcode
        vecs.push_back(fr(X_OP, 1));
        vecs.push_back(dr(X_OP, 3'd0));
        vecs.push_back(mk(X_OP, 3'd0, 0, 1, S_TRAP, 0, 0, 0, 0, 0, 2'd0, 0, 2'd0, 2'd0, 0, 2'd0, 0, 1));

        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < vecs.size(); i++) apply(vecs[i], $sformatf("vec%0d", i));

        // TRAP stays put for 100 cycles whatever the inputs do
        for (int i = 0; i < 100; i++)
            apply(mk(R_OP, 3'(i), 1'(i), 1'(i >> 1), S_TRAP, 0, 0, 0, 0, 0, 2'd0, 0, 2'd0, 2'd0, 0, 2'd0, 0, 1),
                  $sformatf("trap%0d", i));

        // Reset pulse clears the trap without a clock edge
        rst_n = 1'b0;
        #1;
        check("trap_reset_state", {28'd0, state}, {28'd0, S_FETCH});
        check("trap_reset_illegal", {31'd0, illegal}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // Reset in the middle of a store wait drops the request immediately
        apply(fr(S_OP, 1), "sw_fetch");
        apply(dr(S_OP, 3'd2), "sw_decode");
        apply(mk(S_OP, 3'd2, 0, 1, S_MEM_ADDR, 0, 0, 0, 0, 0, 2'd0, 0, 2'd2, 2'd1, 0, 2'd0, 0, 0), "sw_addr");
        apply(mk(S_OP, 3'd2, 0, 0, S_MEM_WR, 1, 1, 0, 0, 0, 2'd0, 0, 2'd0, 2'd0, 0, 2'd0, 0, 0), "sw_wait");
        check("midwr_before", {30'd0, mem_req, mem_we}, 32'd3);
        rst_n = 1'b0;
        #1;
        check("midwr_drop", {30'd0, mem_req, mem_we}, 32'd0);
        check("midwr_state", {28'd0, state}, {28'd0, S_FETCH});
        @(negedge clk);
        mem_ready = 1'b0;
        rst_n     = 1'b1;
        #1;
        check("post_reset_fetch", {26'd0, state, mem_req, mem_we}, {26'd0, S_FETCH, 2'b10});

        $display("%0d/%0d checks passed", pass_cnt, total);
        $finish;
    end

endmodule
